// File: rtl/counter.sv
// Free-running Size-bit up-counter, wraps modulo 2^Size; synchronous active-high reset to zero.
// Latency: count changes one clock edge after reset/increment; no handshake, so no backpressure.
module counter #(
  parameter int Size = 5
) (
  input  logic            clock,
  input  logic            reset,
  output logic [Size-1:0] count
);

  // Reset wins over increment; the MSB carry is dropped, giving the wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count + Size'(1);
    end
  end

endmodule

// File: tb/tb_counter.sv
// Scoreboard bench for counter at Size = 5 and Size = 8: stimulus pushes expected counts,
// per-instance monitors pop and compare just after each rising edge.
module tb_counter;

  logic       clock;
  logic       reset5;
  logic       reset8;
  logic [4:0] count5;
  logic [7:0] count8;

  logic [4:0] q5[$];
  logic [7:0] q8[$];

  int checks;
  int passes;

  counter #(.Size(5)) dut5 (
    .clock(clock),
    .reset(reset5),
    .count(count5)
  );

  counter #(.Size(8)) dut8 (
    .clock(clock),
    .reset(reset8),
    .count(count8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step5(input logic r, input logic [4:0] exp);
    @(negedge clock);
    reset5 = r;
    @(posedge clock);
    q5.push_back(exp);
  endtask

  task automatic step8(input logic r, input logic [7:0] exp);
    @(negedge clock);
    reset8 = r;
    @(posedge clock);
    q8.push_back(exp);
  endtask

  // Reset pulses between edges but is low when the edge samples it.
  task automatic glitch5(input logic [4:0] exp);
    @(negedge clock);
    reset5 = 1'b1;
    #2;
    reset5 = 1'b0;
    @(posedge clock);
    q5.push_back(exp);
  endtask

  always @(posedge clock) begin
    #1;
    if (q5.size() > 0) begin
      logic [4:0] e;
      e = q5.pop_front();
      checks++;
      if (count5 === e) passes++;
      else $display("FAIL count5 check %0d: got %0d, expected %0d", checks, count5, e);
    end
  end

  always @(posedge clock) begin
    #1;
    if (q8.size() > 0) begin
      logic [7:0] e;
      e = q8.pop_front();
      checks++;
      if (count8 === e) passes++;
      else $display("FAIL count8 check %0d: got %0d, expected %0d", checks, count8, e);
    end
  end

  initial begin
    checks = 0;
    passes = 0;
    reset5 = 1'b1;
    reset8 = 1'b1;

    // Reset, first counts, full run through the wrap and one past it.
    step5(1'b1, 5'd0);
    step5(1'b0, 5'd1);
    step5(1'b0, 5'd2);
    step5(1'b0, 5'd3);
    for (int i = 4; i <= 31; i++) step5(1'b0, 5'(i));
    step5(1'b0, 5'd0);
    step5(1'b0, 5'd1);

    // Reset mid-count at 17.
    step5(1'b1, 5'd0);
    for (int i = 1; i <= 17; i++) step5(1'b0, 5'(i));
    step5(1'b1, 5'd0);
    step5(1'b0, 5'd1);
    step5(1'b0, 5'd2);

    // Reset held for 10 edges.
    for (int i = 0; i < 10; i++) step5(1'b1, 5'd0);
    step5(1'b0, 5'd1);

    // Reset between edges is ignored.
    glitch5(5'd2);
    step5(1'b0, 5'd3);

    // Reset at all ones must give 0, then restart at 1.
    step5(1'b1, 5'd0);
    for (int i = 1; i <= 31; i++) step5(1'b0, 5'(i));
    step5(1'b1, 5'd0);
    step5(1'b0, 5'd1);

    // Size = 8: 255 after 255 edges, 0 on the 256th.
    step8(1'b1, 8'd0);
    for (int i = 1; i <= 255; i++) step8(1'b0, 8'(i));
    step8(1'b0, 8'd0);
    step8(1'b0, 8'd1);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && (q5.size() > 0 || q8.size() > 0); i++) @(posedge clock);
    #2;
    if (q5.size() > 0 || q8.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d entries left, expected 0", q5.size() + q8.size());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
